// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-step sequencer: the 4-bit load/store op encoding,
// the sequencer FSM states and op classification helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_SW  = 4'd0,
        OP_SH  = 4'd1,
        OP_SB  = 4'd2,
        OP_LW  = 4'd3,
        OP_LH  = 4'd4,
        OP_LB  = 4'd5,
        OP_LBU = 4'd6,
        OP_LHU = 4'd7,
        OP_LWU = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_FMT,
        ST_WR,
        ST_DONE
    } seq_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return op <= OP_SB;
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LWU);
    endfunction

endpackage

// File: rtl/data_mem_sequencer_if.sv
// Bundle of the control request/response, data-memory and byte-formatter signals
// seen by the sequencer; slave is the sequencer's view, master the surroundings'.
interface data_mem_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              flush;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [3:0]        fmt_sel;
    logic [DATA_W-1:0] fmt_b;
    logic [DATA_W-1:0] fmt_mem;
    logic [DATA_W-1:0] fmt_out;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, flush, mem_rdata, fmt_out,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
        output fmt_sel, fmt_b, fmt_mem, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, flush, mem_rdata, fmt_out,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
        input  fmt_sel, fmt_b, fmt_mem, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/data_mem_sequencer.sv
// Multicycle MEM-step sequencer: reads the addressed doubleword, routes it through the
// external byte formatter and either returns the load result or writes back the merged store.
module data_mem_sequencer
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_sequencer_if.slave bus
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    seq_state_e        state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              resp_valid_q;
    logic              err_q;

    // Outputs are registered and set on entry to the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            result_q     <= '0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && bus.req_valid) begin
                        op_q    <= bus.req_op;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        ready_q <= 1'b0;
                        if (is_load(bus.req_op) || is_store(bus.req_op)) begin
                            state_q  <= ST_RD;
                            cnt_q    <= CNT_INIT;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state_q      <= ST_DONE;
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                        end
                    end
                end
                ST_RD: begin
                    if (bus.flush) begin
                        state_q  <= ST_IDLE;
                        mem_rd_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rdata_q  <= bus.mem_rdata;
                        mem_rd_q <= 1'b0;
                        state_q  <= ST_FMT;
                    end
                end
                ST_FMT: begin
                    result_q <= bus.fmt_out;
                    if (is_store(op_q)) begin
                        state_q  <= ST_WR;
                        mem_wr_q <= 1'b1;
                    end else begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= bus.fmt_out;
                    end
                end
                // Flush is deliberately not looked at here so a started store always lands.
                ST_WR: begin
                    mem_wr_q     <= 1'b0;
                    state_q      <= ST_DONE;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= '0;
                end
                ST_DONE: begin
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= '0;
                    err_q        <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_wdata  = result_q;
    assign bus.fmt_sel    = op_q;
    assign bus.fmt_b      = wdata_q;
    assign bus.fmt_mem    = rdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = err_q;

    a_latency_range: assert property (@(posedge clk) (MEM_LATENCY >= 1) && (MEM_LATENCY <= 15));
    a_rd_wr_mutex:   assert property (@(posedge clk) disable iff (!reset) !(mem_rd_q && mem_wr_q));

endmodule
